// File: rtl/agc_power_seq.sv
// AGC power sequencer: brings up the switched +4 V supply, holds STRT2 for
// the restart interval, then runs. A filtered standby-relay request drops the
// supply into standby, and releasing it wakes the AGC through a full power-up.
module agc_power_seq #(
  parameter int STRT2_CYCLES = 409600,
  parameter int PWR_DLY      = 2048,
  parameter int CNT_W        = 19
) (
  input  logic       CLOCK,
  input  logic       rst_n,
  input  logic       sbyrel_n,
  input  logic       restart_req,
  output logic       p4vsw,
  output logic       strt2,
  output logic       sby_active,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    HOLD  = 3'd1,
    RUN   = 3'd2,
    DROP  = 3'd3,
    STBY  = 3'd4
  } state_t;

  // Counter load values: a state with load N-1 lasts exactly N cycles.
  localparam logic [CNT_W-1:0] PWR_LOAD   = CNT_W'(PWR_DLY - 1);
  localparam logic [CNT_W-1:0] STRT2_LOAD = CNT_W'(STRT2_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             p4vsw_q, p4vsw_d;
  logic             strt2_q, strt2_d;
  logic             sby_q, sby_d;

  logic             sync1_q, sync2_q, hist_q;
  logic             sby_req, sby_clr;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_dec;

  // Two-flop synchronizer for the relay input plus one history flop for the
  // two-cycle persistence filter; idle level (relay released) is 1.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
    end else begin
      sync1_q <= sbyrel_n;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
    end
  end

  // A level only counts once the synchronized input has held it two cycles.
  assign sby_req  = ~sync2_q & ~hist_q;
  assign sby_clr  =  sync2_q &  hist_q;

  // Saturating decrement keeps the counter from wrapping below zero.
  assign cnt_zero = (cnt_q == '0);
  assign cnt_dec  = cnt_zero ? cnt_q : (cnt_q - CNT_ONE);

  // Next-state, counter reload on every state entry, and output decode of
  // the next state so the registered outputs track the state register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_dec;
    case (state_q)
      PWRUP: begin
        if (cnt_zero) begin
          state_d = HOLD;
          cnt_d   = STRT2_LOAD;
        end
      end
      HOLD: begin
        // A restart request while holding extends STRT2 from this point.
        if (restart_req) begin
          cnt_d = STRT2_LOAD;
        end else if (cnt_zero) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Standby has priority over a simultaneous restart request.
        if (sby_req) begin
          state_d = DROP;
          cnt_d   = PWR_LOAD;
        end else if (restart_req) begin
          state_d = HOLD;
          cnt_d   = STRT2_LOAD;
        end
      end
      DROP: begin
        if (cnt_zero) begin
          state_d = STBY;
          cnt_d   = '0;
        end
      end
      STBY: begin
        if (sby_clr) begin
          state_d = PWRUP;
          cnt_d   = PWR_LOAD;
        end
      end
      default: begin
        // Unused encodings recover through a normal power-up.
        state_d = PWRUP;
        cnt_d   = PWR_LOAD;
      end
    endcase

    p4vsw_d = (state_d == HOLD)  || (state_d == RUN);
    strt2_d = (state_d == PWRUP) || (state_d == HOLD);
    sby_d   = (state_d == STBY);
  end

  // State, counter and output registers; reset forces the power-up values.
  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PWRUP;
      cnt_q   <= PWR_LOAD;
      p4vsw_q <= 1'b0;
      strt2_q <= 1'b1;
      sby_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p4vsw_q <= p4vsw_d;
      strt2_q <= strt2_d;
      sby_q   <= sby_d;
    end
  end

  assign p4vsw      = p4vsw_q;
  assign strt2      = strt2_q;
  assign sby_active = sby_q;
  assign state      = state_q;

endmodule

// File: tb/tb_agc_power_seq.sv
// Bench for agc_power_seq with short timing (STRT2 16 cycles, supply 4 cycles).
module tb_agc_power_seq;

  localparam int S = 16;
  localparam int P = 4;

  logic       CLOCK;
  logic       rst_n;
  logic       sbyrel_n;
  logic       restart_req;
  logic       p4vsw;
  logic       strt2;
  logic       sby_active;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  agc_power_seq #(
    .STRT2_CYCLES(S),
    .PWR_DLY     (P),
    .CNT_W       (19)
  ) dut (
    .CLOCK      (CLOCK),
    .rst_n      (rst_n),
    .sbyrel_n   (sbyrel_n),
    .restart_req(restart_req),
    .p4vsw      (p4vsw),
    .strt2      (strt2),
    .sby_active (sby_active),
    .state      (state)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Model: current mode (0..4) and number of cycles left in it; the relay
  // input is remembered as the values seen at the last three clock edges.
  int m_mode = 0;
  int m_rem  = P;
  bit h0 = 1'b1, h1 = 1'b1, h2 = 1'b1;
  bit m_req, m_clr;

  always @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_rem = P;
      h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
    end else begin
      // The relay level counts once seen at the edges two and three back.
      m_req = !h1 && !h2;
      m_clr =  h1 &&  h2;
      case (m_mode)
        0: if (m_rem == 1) begin m_mode = 1; m_rem = S; end else m_rem--;
        1: if (restart_req) m_rem = S;
           else if (m_rem == 1) m_mode = 2;
           else m_rem--;
        2: if (m_req) begin m_mode = 3; m_rem = P; end
           else if (restart_req) begin m_mode = 1; m_rem = S; end
        3: if (m_rem == 1) m_mode = 4; else m_rem--;
        4: if (m_clr) begin m_mode = 0; m_rem = P; end
        default: m_mode = 0;
      endcase
      h2 = h1; h1 = h0; h0 = sbyrel_n;
    end
  end

  // Cycle-by-cycle compare of all outputs against the model.
  always @(negedge CLOCK) begin
    if (rst_n) begin
      chk("cyc_state", int'(state), m_mode);
      chk("cyc_p4vsw", int'(p4vsw), int'(m_mode == 1 || m_mode == 2));
      chk("cyc_strt2", int'(strt2), int'(m_mode == 0 || m_mode == 1));
      chk("cyc_sby",   int'(sby_active), int'(m_mode == 4));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  task automatic pulse_restart();
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
  endtask

  // Full power-on sequence from reset release: 4 cycles PWRUP, 16 HOLD.
  task automatic power_on(input string tag);
    rst_n = 1'b1;
    step(3);
    chk({tag, "_pwrup_state"}, int'(state), 0);
    chk({tag, "_pwrup_p4vsw"}, int'(p4vsw), 0);
    step(1);
    chk({tag, "_edge4_p4vsw"}, int'(p4vsw), 1);
    chk({tag, "_edge4_state"}, int'(state), 1);
    step(15);
    chk({tag, "_edge19_strt2"}, int'(strt2), 1);
    step(1);
    chk({tag, "_edge20_strt2"}, int'(strt2), 0);
    chk({tag, "_edge20_state"}, int'(state), 2);
  endtask

  initial begin
    rst_n = 1'b0; sbyrel_n = 1'b1; restart_req = 1'b0;
    step(3);
    chk("rst_state", int'(state), 0);
    chk("rst_p4vsw", int'(p4vsw), 0);
    chk("rst_strt2", int'(strt2), 1);
    chk("rst_sby",   int'(sby_active), 0);

    power_on("pon");
    step(2);

    // One-cycle relay glitch in RUN is filtered out.
    sbyrel_n = 1'b0; step(1); sbyrel_n = 1'b1;
    step(6);
    chk("glitch_state", int'(state), 2);
    chk("glitch_p4vsw", int'(p4vsw), 1);

    // Restart alone in RUN: STRT2 for exactly 16 cycles.
    pulse_restart();
    chk("rst_req_state", int'(state), 1);
    chk("rst_req_strt2", int'(strt2), 1);
    step(15);
    chk("rst_req_c16_strt2", int'(strt2), 1);
    step(1);
    chk("rst_req_c17_strt2", int'(strt2), 0);
    step(2);

    // Restart in HOLD at cnt=3 extends HOLD by 16 cycles from that edge.
    pulse_restart();
    step(12);
    pulse_restart();
    chk("ext_state", int'(state), 1);
    step(15);
    chk("ext_c16_strt2", int'(strt2), 1);
    step(1);
    chk("ext_c17_strt2", int'(strt2), 0);
    chk("ext_c17_state", int'(state), 2);
    step(2);

    // Standby request coinciding with a restart: standby wins.
    sbyrel_n = 1'b0;
    step(3);
    chk("sim_pre_p4vsw", int'(p4vsw), 1);
    pulse_restart();
    chk("sim_state", int'(state), 3);
    chk("sim_strt2", int'(strt2), 0);
    chk("sim_p4vsw", int'(p4vsw), 0);
    pulse_restart();   // ignored in DROP
    step(2);
    chk("drop_c4_state", int'(state), 3);
    step(1);
    chk("stby_state", int'(state), 4);
    chk("stby_sby", int'(sby_active), 1);
    pulse_restart();   // ignored in STBY
    chk("stby_rst_state", int'(state), 4);

    // Wake: PWRUP 4 cycles, HOLD 16 cycles, then RUN.
    sbyrel_n = 1'b1;
    step(3);
    chk("wake_pre_state", int'(state), 4);
    step(1);
    chk("wake_state", int'(state), 0);
    chk("wake_strt2", int'(strt2), 1);
    step(3);
    chk("wake_pwrup_end", int'(state), 0);
    step(1);
    chk("wake_hold_state", int'(state), 1);
    step(15);
    chk("wake_hold_end", int'(state), 1);
    step(1);
    chk("wake_run_state", int'(state), 2);
    step(2);

    // Asynchronous reset mid-HOLD at cnt=7, then a full repeat sequence.
    pulse_restart();
    step(8);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_p4vsw", int'(p4vsw), 0);
    chk("async_strt2", int'(strt2), 1);
    chk("async_sby",   int'(sby_active), 0);
    step(2);
    power_on("rep");
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
